// File: rtl/apb_regfile_slave_pkg.sv
// Encodings shared by the AHB-to-APB bridge and its APB register-bank completers.
package apb_regfile_slave_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      DONE
   } apb_slv_state_t;

   localparam logic READY     = 1'b1;
   localparam logic NOT_READY = 1'b0;
   localparam logic ERROR     = 1'b1;
   localparam logic NO_ERROR  = 1'b0;
   localparam logic RW        = 1'b0;
   localparam logic RO        = 1'b1;

   // Wait counter sized for the largest supported WAIT_STATES (15).
   localparam int unsigned CTR_W = $clog2(16);

   function automatic logic is_word_aligned(input logic [1:0] lsbs);
      return lsbs == 2'b00;
   endfunction

endpackage

// File: rtl/apb_regfile_slave_if.sv
// APB3 signal bundle for one PSELx lane; master = bridge side, slave = completer side.
interface apb_regfile_slave_if #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32
);
   logic                  PSEL;
   logic                  PENABLE;
   logic                  PWRITE;
   logic [ADDR_WIDTH-1:0] PADDR;
   logic [DATA_WIDTH-1:0] PWDATA;
   logic [DATA_WIDTH-1:0] PRDATA;
   logic                  PREADY;
   logic                  PSLVERR;

   modport master (
      output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
      input  PRDATA, PREADY, PSLVERR
   );

   modport slave (
      input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
      output PRDATA, PREADY, PSLVERR
   );
endinterface

// File: rtl/apb_regfile_slave_wait_ctr.sv
// Access-phase wait-state counter: load at setup, count down while the access is held.
module apb_wait_ctr
   import apb_regfile_slave_pkg::*;
#(
   parameter int unsigned WIDTH = CTR_W
) (
   input  logic             HCLK,
   input  logic             HRESETn,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             dec,
   output logic             zero,
   output logic             last
);

   logic [WIDTH-1:0] cnt;

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (dec && (cnt != '0)) begin
         cnt <= cnt - 1'b1;
      end
   end

   assign zero = (cnt == '0);
   assign last = (cnt == WIDTH'(1));

endmodule

// File: rtl/apb_regfile_slave.sv
// APB3 completer: word register bank with read-only ID at word 0, fixed wait states and PSLVERR.
module apb_regfile_slave
   import apb_regfile_slave_pkg::*;
#(
   parameter int unsigned           ADDR_WIDTH  = 32,
   parameter int unsigned           DATA_WIDTH  = 32,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = 32'h100,
   parameter int unsigned           NUM_REGS    = 16,
   parameter int unsigned           WAIT_STATES = 2,
   parameter logic [DATA_WIDTH-1:0] ID_VALUE    = 32'hA2B0_0001
) (
   input logic                HCLK,
   input logic                HRESETn,
   apb_regfile_slave_if.slave apb
);

   localparam int unsigned           IDX_W = $clog2(NUM_REGS);
   localparam logic [ADDR_WIDTH-1:0] SPAN  = ADDR_WIDTH'(4 * NUM_REGS);

   apb_slv_state_t        state;
   logic [DATA_WIDTH-1:0] regs [NUM_REGS];

   logic [IDX_W-1:0]      addr_idx;
   logic                  wr_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic                  err_q;

   logic                  pready_q;
   logic                  pslverr_q;
   logic [DATA_WIDTH-1:0] prdata_q;

   logic [ADDR_WIDTH-1:0] offset;
   logic [IDX_W-1:0]      dec_idx;
   logic                  dec_err;
   logic                  setup;
   logic [DATA_WIDTH-1:0] rd_setup;
   logic [DATA_WIDTH-1:0] rd_hold;

   logic                  ctr_dec;
   logic                  ctr_zero;
   logic                  ctr_last;

   always_comb begin
      offset   = apb.PADDR - BASE_ADDR;
      dec_idx  = offset[IDX_W+1:2];
      dec_err  = (apb.PADDR < BASE_ADDR)
               | (offset >= SPAN)
               | !is_word_aligned(apb.PADDR[1:0])
               | (apb.PWRITE && (((dec_idx == '0) ? RO : RW) == RO));
      setup    = (state != ACCESS) && apb.PSEL && !apb.PENABLE;
      rd_setup = (dec_idx == '0) ? ID_VALUE : regs[dec_idx];
      rd_hold  = (addr_idx == '0) ? ID_VALUE : regs[addr_idx];
      ctr_dec  = (state == ACCESS) && apb.PSEL && apb.PENABLE && !ctr_zero;
   end

   apb_wait_ctr #(
      .WIDTH (CTR_W)
   ) u_wait_ctr (
      .HCLK     (HCLK),
      .HRESETn  (HRESETn),
      .load     (setup),
      .load_val (CTR_W'(WAIT_STATES)),
      .dec      (ctr_dec),
      .zero     (ctr_zero),
      .last     (ctr_last)
   );

   // Outputs are registered one cycle ahead: PREADY rises on the edge where the
   // counter steps to zero, or straight out of setup when there are no wait states.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state     <= IDLE;
         addr_idx  <= '0;
         wr_q      <= 1'b0;
         wdata_q   <= '0;
         err_q     <= NO_ERROR;
         pready_q  <= NOT_READY;
         pslverr_q <= NO_ERROR;
         prdata_q  <= '0;
         for (int unsigned i = 0; i < NUM_REGS; i++) begin
            regs[i] <= '0;
         end
      end else begin
         unique case (state)
            IDLE, DONE: begin
               pready_q  <= NOT_READY;
               pslverr_q <= NO_ERROR;
               prdata_q  <= '0;
               if (setup) begin
                  state    <= ACCESS;
                  addr_idx <= dec_idx;
                  wr_q     <= apb.PWRITE;
                  wdata_q  <= apb.PWDATA;
                  err_q    <= dec_err;
                  if (WAIT_STATES == 0) begin
                     pready_q  <= READY;
                     pslverr_q <= dec_err;
                     prdata_q  <= (!apb.PWRITE && !dec_err) ? rd_setup : '0;
                  end
               end else begin
                  state <= IDLE;
               end
            end
            ACCESS: begin
               if (!apb.PSEL) begin
                  state     <= IDLE;
                  pready_q  <= NOT_READY;
                  pslverr_q <= NO_ERROR;
                  prdata_q  <= '0;
               end else if (apb.PENABLE) begin
                  if (pready_q) begin
                     if (wr_q && !err_q) begin
                        regs[addr_idx] <= wdata_q;
                     end
                     state     <= DONE;
                     pready_q  <= NOT_READY;
                     pslverr_q <= NO_ERROR;
                     prdata_q  <= '0;
                  end else if (ctr_last) begin
                     pready_q  <= READY;
                     pslverr_q <= err_q;
                     prdata_q  <= (!wr_q && !err_q) ? rd_hold : '0;
                  end
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign apb.PREADY  = pready_q;
   assign apb.PSLVERR = pslverr_q;
   assign apb.PRDATA  = prdata_q;

endmodule

// File: tb/tb_apb_regfile_slave.sv
// Bench for apb_regfile_slave: a 2-wait-state and a zero-wait instance driven from one vector table.
module tb_apb_regfile_slave;

   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;
   localparam logic [31:0] ID = 32'hA2B0_0001;

   logic HCLK = 1'b0;
   logic HRESETn;

   always #5 HCLK = ~HCLK;

   apb_regfile_slave_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus2 ();
   apb_regfile_slave_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus0 ();

   apb_regfile_slave #(
      .ADDR_WIDTH (AW), .DATA_WIDTH (DW), .BASE_ADDR (32'h100),
      .NUM_REGS (16), .WAIT_STATES (2), .ID_VALUE (ID)
   ) u_dut (
      .HCLK (HCLK), .HRESETn (HRESETn), .apb (bus2)
   );

   apb_regfile_slave #(
      .ADDR_WIDTH (AW), .DATA_WIDTH (DW), .BASE_ADDR (32'h100),
      .NUM_REGS (16), .WAIT_STATES (0), .ID_VALUE (ID)
   ) u_dut0 (
      .HCLK (HCLK), .HRESETn (HRESETn), .apb (bus0)
   );

   typedef struct {
      logic        sel0;
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      logic        exp_err;
   } vec_t;

   typedef struct {
      logic        wr;
      logic [31:0] rdata;
      logic        err;
   } exp_t;

   vec_t vecs[$];
   exp_t sb_q[$];
   int   checks = 0;
   int   errors = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, got, exp);
      end
   endtask

   task automatic drive(input logic sel0, input logic psel, input logic pen, input logic pwr,
                        input logic [31:0] pa, input logic [31:0] pd);
      if (sel0) begin
         bus0.PSEL = psel; bus0.PENABLE = pen; bus0.PWRITE = pwr; bus0.PADDR = pa; bus0.PWDATA = pd;
      end else begin
         bus2.PSEL = psel; bus2.PENABLE = pen; bus2.PWRITE = pwr; bus2.PADDR = pa; bus2.PWDATA = pd;
      end
   endtask

   function automatic logic s_ready(input logic sel0);
      return sel0 ? bus0.PREADY : bus2.PREADY;
   endfunction

   function automatic logic s_err(input logic sel0);
      return sel0 ? bus0.PSLVERR : bus2.PSLVERR;
   endfunction

   function automatic logic [31:0] s_rdata(input logic sel0);
      return sel0 ? bus0.PRDATA : bus2.PRDATA;
   endfunction

   // One complete transfer, starting #1 after a rising edge; the next call may follow with no idle cycle.
   task automatic xfer(input logic sel0, input logic wr, input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] exp_rd, input logic exp_err);
      int unsigned ws   = sel0 ? 0 : 2;
      int unsigned cyc  = 0;
      logic        done = 1'b0;
      time         t0;
      exp_t        e;
      e.wr = wr; e.rdata = exp_rd; e.err = exp_err;
      sb_q.push_back(e);
      t0 = $time;
      drive(sel0, 1'b1, 1'b0, wr, a, d);
      @(negedge HCLK);
      check("setup_pready", {31'd0, s_ready(sel0)}, 32'd0);
      @(posedge HCLK); #1;
      // Address/data move during the access phase; the completer must use the setup values.
      drive(sel0, 1'b1, 1'b1, wr, a ^ 32'h4, ~d);
      while (!done && cyc < 40) begin
         @(negedge HCLK);
         cyc++;
         if (s_ready(sel0)) done = 1'b1;
         else check("wait_pslverr", {31'd0, s_err(sel0)}, 32'd0);
      end
      if (!done) begin
         errors++;
         $display("FAIL timeout: addr %h got no PREADY in %0d cycles, expected %0d", a, cyc, ws + 1);
         if (sb_q.size() != 0) void'(sb_q.pop_front());
         @(posedge HCLK); #1;
      end else begin
         check("access_cycles", cyc, ws + 1);
         if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard: got completion at %h, expected none queued", a);
         end else begin
            e = sb_q.pop_front();
            check("pslverr", {31'd0, s_err(sel0)}, {31'd0, e.err});
            check(e.wr ? "prdata_on_write" : "prdata", s_rdata(sel0), e.wr ? 32'd0 : e.rdata);
         end
         @(posedge HCLK); #1;
         check("xfer_time", 32'($time - t0), (ws + 2) * 10);
      end
      drive(sel0, 1'b0, 1'b0, 1'b0, '0, '0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no end of test by %0t, expected earlier", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      vecs.push_back('{1'b0, 1'b0, 32'h104, 32'h0,         32'h0,         1'b0});
      vecs.push_back('{1'b0, 1'b1, 32'h108, 32'hDEAD_BEEF, 32'h0,         1'b0});
      vecs.push_back('{1'b0, 1'b0, 32'h108, 32'h0,         32'hDEAD_BEEF, 1'b0});
      vecs.push_back('{1'b0, 1'b0, 32'h100, 32'h0,         ID,            1'b0});
      vecs.push_back('{1'b0, 1'b1, 32'h100, 32'h1,         32'h0,         1'b1});
      vecs.push_back('{1'b0, 1'b0, 32'h100, 32'h0,         ID,            1'b0});
      vecs.push_back('{1'b0, 1'b0, 32'h0FC, 32'h0,         32'h0,         1'b1});
      vecs.push_back('{1'b0, 1'b0, 32'h140, 32'h0,         32'h0,         1'b1});
      vecs.push_back('{1'b0, 1'b0, 32'h102, 32'h0,         32'h0,         1'b1});
      vecs.push_back('{1'b0, 1'b1, 32'h13C, 32'h1234_5678, 32'h0,         1'b0});
      vecs.push_back('{1'b0, 1'b0, 32'h13C, 32'h0,         32'h1234_5678, 1'b0});
      vecs.push_back('{1'b0, 1'b1, 32'h140, 32'h0000_FFFF, 32'h0,         1'b1});
      vecs.push_back('{1'b0, 1'b0, 32'h108, 32'h0,         32'hDEAD_BEEF, 1'b0});
      vecs.push_back('{1'b0, 1'b1, 32'h104, 32'h5,         32'h0,         1'b0});
      vecs.push_back('{1'b0, 1'b0, 32'h104, 32'h0,         32'h5,         1'b0});
      vecs.push_back('{1'b0, 1'b1, 32'h10E, 32'h9,         32'h0,         1'b1});
      vecs.push_back('{1'b0, 1'b0, 32'h10C, 32'h0,         32'h0,         1'b0});
      vecs.push_back('{1'b1, 1'b1, 32'h104, 32'h5,         32'h0,         1'b0});
      vecs.push_back('{1'b1, 1'b0, 32'h104, 32'h0,         32'h5,         1'b0});
      vecs.push_back('{1'b1, 1'b0, 32'h100, 32'h0,         ID,            1'b0});
      vecs.push_back('{1'b1, 1'b0, 32'h102, 32'h0,         32'h0,         1'b1});
      vecs.push_back('{1'b1, 1'b1, 32'h0FC, 32'h3,         32'h0,         1'b1});
      vecs.push_back('{1'b1, 1'b0, 32'h108, 32'h0,         32'h0,         1'b0});

      drive(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
      drive(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
      HRESETn = 1'b0;
      repeat (3) @(posedge HCLK);
      @(negedge HCLK);
      check("rst_pready",  {31'd0, bus2.PREADY},  32'd0);
      check("rst_pslverr", {31'd0, bus2.PSLVERR}, 32'd0);
      check("rst_prdata",  bus2.PRDATA,           32'd0);
      check("rst_pready0", {31'd0, bus0.PREADY},  32'd0);
      @(posedge HCLK); #1;
      HRESETn = 1'b1;
      @(posedge HCLK); #1;

      foreach (vecs[i]) begin
         xfer(vecs[i].sel0, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata, vecs[i].exp_err);
      end

      // Abort: PSEL drops during the first wait cycle of a write.
      drive(1'b0, 1'b1, 1'b0, 1'b1, 32'h10C, 32'h7);
      @(posedge HCLK); #1;
      drive(1'b0, 1'b1, 1'b1, 1'b1, 32'h10C, 32'h7);
      @(negedge HCLK);
      check("abort_wait_pready", {31'd0, bus2.PREADY}, 32'd0);
      drive(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
      repeat (3) begin
         @(negedge HCLK);
         check("abort_pready", {31'd0, bus2.PREADY}, 32'd0);
      end
      @(posedge HCLK); #1;
      xfer(1'b0, 1'b0, 32'h10C, 32'h0, 32'h0, 1'b0);

      // Access phase without a setup phase is ignored.
      drive(1'b0, 1'b1, 1'b1, 1'b1, 32'h110, 32'hBAD);
      repeat (4) begin
         @(negedge HCLK);
         check("nosetup_pready", {31'd0, bus2.PREADY}, 32'd0);
      end
      @(posedge HCLK); #1;
      drive(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
      xfer(1'b0, 1'b0, 32'h110, 32'h0, 32'h0, 1'b0);

      // Asynchronous reset between edges while a read is completing.
      drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h108, 32'h0);
      @(posedge HCLK); #1;
      drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h108, 32'h0);
      repeat (3) @(negedge HCLK);
      check("pre_rst_pready", {31'd0, bus2.PREADY}, 32'd1);
      check("pre_rst_prdata", bus2.PRDATA, 32'hDEAD_BEEF);
      #1 HRESETn = 1'b0;
      #1;
      check("async_rst_pready",  {31'd0, bus2.PREADY},  32'd0);
      check("async_rst_pslverr", {31'd0, bus2.PSLVERR}, 32'd0);
      check("async_rst_prdata",  bus2.PRDATA,           32'd0);
      drive(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
      @(posedge HCLK); #1;
      HRESETn = 1'b1;
      @(posedge HCLK); #1;
      xfer(1'b0, 1'b0, 32'h104, 32'h0, 32'h0, 1'b0);
      xfer(1'b0, 1'b0, 32'h108, 32'h0, 32'h0, 1'b0);
      xfer(1'b0, 1'b0, 32'h100, 32'h0, ID,    1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
